// File: rtl/foh_pkg.sv
// ============================================================================
// foh_pkg : shared codes, default widths and width helpers for the FOH datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

package foh_pkg;

    localparam logic [2:0] REG_HOLD = 3'b000;
    localparam logic [2:0] REG_LOAD = 3'b001;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_LOG2_N = 3;

    // Accumulator holds A*N plus up to N-1 slope steps, so it needs LOG2_N extra bits and a sign bit.
    function automatic int acc_width(input int data_w, input int log2_n);
        return data_w + log2_n + 1;
    endfunction

    function automatic int cnt_width(input int log2_n);
        return $clog2(log2_n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/foh_shift_engine.sv
// ============================================================================
// foh_shift_engine : snapshots ACC, shifts it right by LOG2_N one bit per cycle
// and strobes the final value out.  Revision: 1.0
// ============================================================================
`default_nettype none

module foh_shift_engine
    import foh_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LOG2_N = DEF_LOG2_N
) (
    input  logic                                    CLOCK,
    input  logic                                    RESET,
    input  logic                                    start,
    input  logic signed [acc_width(DATA_W, LOG2_N)-1:0] acc_in,
    output logic [DATA_W-1:0]                       interp_out,
    output logic                                    interp_valid,
    output logic                                    shift_done
);

    localparam int ACC_W = acc_width(DATA_W, LOG2_N);
    localparam int CNT_W = cnt_width(LOG2_N);

    logic signed [ACC_W-1:0] r_shreg;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_W-1:0]       r_out;
    logic                    r_pulse;
    logic signed [ACC_W-1:0] w_shifted;

    assign w_shifted = r_shreg >>> 1;

    // A new start always wins, which silently abandons any shift already in flight.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_pulse <= 1'b0;
        end else if (start) begin
            r_shreg <= acc_in;
            r_cnt   <= CNT_W'(LOG2_N);
            r_pulse <= 1'b0;
        end else if (r_cnt != '0) begin
            r_shreg <= w_shifted;
            r_cnt   <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_out   <= w_shifted[DATA_W-1:0];
                r_pulse <= 1'b1;
            end else begin
                r_pulse <= 1'b0;
            end
        end else begin
            r_pulse <= 1'b0;
        end
    end

    assign interp_out   = r_out;
    assign interp_valid = r_pulse;
    assign shift_done   = r_pulse;

endmodule

`default_nettype wire

// File: rtl/foh_interp_datapath.sv
// ============================================================================
// foh_interp_datapath : A/B sample registers, slope D, accumulator and point
// counter for the first-order-hold interpolator.  Revision: 1.0
// ============================================================================
`default_nettype none

module foh_interp_datapath
    import foh_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LOG2_N = DEF_LOG2_N
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [2:0]        RegA,
    input  logic [2:0]        RegB,
    input  logic [2:0]        RegC,
    input  logic              init_C,
    input  logic              interpolate_count_ENP,
    input  logic              sample_rdy,
    output logic [DATA_W-1:0] interp_out,
    output logic              interp_valid,
    output logic              shift_done,
    output logic              interpolate_count
);

    localparam int ACC_W = acc_width(DATA_W, LOG2_N);
    localparam logic [LOG2_N-1:0] c_k_max = '1;

    logic [DATA_W-1:0]       r_a;
    logic [DATA_W-1:0]       r_b;
    logic signed [DATA_W:0]  r_d;
    logic signed [ACC_W-1:0] r_acc;
    logic [LOG2_N-1:0]       r_k;
    logic signed [ACC_W-1:0] w_d_ext;
    logic signed [ACC_W-1:0] w_seed;

    assign w_d_ext = {{LOG2_N{r_d[DATA_W]}}, r_d};
    assign w_seed  = $signed({1'b0, r_a, {LOG2_N{1'b0}}});

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_a   <= '0;
            r_b   <= '0;
            r_d   <= '0;
            r_acc <= '0;
            r_k   <= '0;
        end else begin
            if (RegA == REG_LOAD) r_a <= sample_in;
            if (RegB == REG_LOAD) r_b <= sample_in;

            if (init_C) begin
                r_d <= $signed({1'b0, r_b}) - $signed({1'b0, r_a});
            end

            if (RegC == REG_LOAD) begin
                r_acc <= init_C ? w_seed : r_acc + w_d_ext;
            end

            // Clearing on init_C takes priority over counting.
            if (init_C) begin
                r_k <= '0;
            end else if (interpolate_count_ENP && (r_k != c_k_max)) begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign interpolate_count = (r_k == c_k_max);

    foh_shift_engine #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_shift_engine (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .start        (sample_rdy),
        .acc_in       (r_acc),
        .interp_out   (interp_out),
        .interp_valid (interp_valid),
        .shift_done   (shift_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_foh_interp_datapath.sv
// ============================================================================
// tb_foh_interp_datapath : directed self-checking bench for foh_interp_datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_foh_interp_datapath;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [11:0] sample_in = '0;
    logic [2:0]  RegA = 3'b000;
    logic [2:0]  RegB = 3'b000;
    logic [2:0]  RegC = 3'b000;
    logic        init_C = 1'b0;
    logic        interpolate_count_ENP = 1'b0;
    logic        sample_rdy = 1'b0;
    logic [11:0] interp_out;
    logic        interp_valid;
    logic        shift_done;
    logic        interpolate_count;

    int n_tests = 0;
    int n_fail  = 0;

    foh_interp_datapath #(
        .DATA_W (12),
        .LOG2_N (3)
    ) dut (
        .CLOCK                 (CLOCK),
        .RESET                 (RESET),
        .sample_in             (sample_in),
        .RegA                  (RegA),
        .RegB                  (RegB),
        .RegC                  (RegC),
        .init_C                (init_C),
        .interpolate_count_ENP (interpolate_count_ENP),
        .sample_rdy            (sample_rdy),
        .interp_out            (interp_out),
        .interp_valid          (interp_valid),
        .shift_done            (shift_done),
        .interpolate_count     (interpolate_count)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set after this apply at the next edge, outputs are sampled here.
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!shift_done && n < 12) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, shift_done}, 32'd1);
    endtask

    task automatic run_ramp(input string tag, input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] exp_v [8]);
        RegA = 3'b001; sample_in = a; tick();
        RegA = 3'b000; RegB = 3'b001; sample_in = b; tick();
        RegB = 3'b000; init_C = 1'b1; tick();
        RegC = 3'b001; tick();
        RegC = 3'b000; init_C = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_icount_%0d", tag, i), {31'd0, interpolate_count},
                  (i == 7) ? 32'd1 : 32'd0);
            sample_rdy = 1'b1; tick();
            sample_rdy = 1'b0;
            wait_done($sformatf("%s_%0d", tag, i));
            check($sformatf("%s_valid_%0d", tag, i), {31'd0, interp_valid}, 32'd1);
            check($sformatf("%s_out_%0d", tag, i), {20'd0, interp_out}, {20'd0, exp_v[i]});
            RegC = 3'b001; interpolate_count_ENP = 1'b1; tick();
            RegC = 3'b000; interpolate_count_ENP = 1'b0;
            check($sformatf("%s_hold_%0d", tag, i), {20'd0, interp_out}, {20'd0, exp_v[i]});
            check($sformatf("%s_strobe_off_%0d", tag, i), {31'd0, interp_valid}, 32'd0);
        end
    endtask

    logic [11:0] rise_v [8];
    logic [11:0] fall_v [8];
    logic [15:0] pulse_at;
    int          pulses;

    initial begin
        rise_v = '{12'd100, 12'd110, 12'd120, 12'd130, 12'd140, 12'd150, 12'd160, 12'd170};
        fall_v = '{12'd200, 12'd192, 12'd184, 12'd176, 12'd168, 12'd160, 12'd152, 12'd144};

        RESET = 1'b1;
        tick(); tick(); tick();
        RESET = 1'b0;
        check("rst_out",    {20'd0, interp_out}, 32'd0);
        check("rst_valid",  {31'd0, interp_valid}, 32'd0);
        check("rst_done",   {31'd0, shift_done}, 32'd0);
        check("rst_icount", {31'd0, interpolate_count}, 32'd0);

        run_ramp("rise", 12'd100, 12'd180, rise_v);
        run_ramp("fall", 12'd200, 12'd137, fall_v);

        // Latency: sample_rdy in cycle t, pulse only in cycle t+4.
        sample_rdy = 1'b1; tick();
        sample_rdy = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("lat_done_t%0d", c), {31'd0, shift_done}, (c == 4) ? 32'd1 : 32'd0);
            check($sformatf("lat_valid_t%0d", c), {31'd0, interp_valid}, (c == 4) ? 32'd1 : 32'd0);
            tick();
        end

        // Retrigger at t+2: one pulse, in cycle t+6.
        pulse_at = '0;
        sample_rdy = 1'b1; tick();
        sample_rdy = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 2) sample_rdy = 1'b1;
            pulse_at[c] = shift_done;
            tick();
            sample_rdy = 1'b0;
        end
        check("retrig_pulses", {16'd0, pulse_at}, 32'h0040);

        // Reset in cycle t+1 aborts the shift.
        pulses = 0;
        sample_rdy = 1'b1; tick();
        sample_rdy = 1'b0; RESET = 1'b1; tick();
        RESET = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (shift_done) pulses++;
            tick();
        end
        check("rst_abort_pulses", pulses, 32'd0);
        check("rst_abort_out", {20'd0, interp_out}, 32'd0);

        // Point counter saturation and clear.
        init_C = 1'b1; tick();
        init_C = 1'b0;
        check("sat_k0", {31'd0, interpolate_count}, 32'd0);
        interpolate_count_ENP = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check($sformatf("sat_enp_%0d", c), {31'd0, interpolate_count}, (c >= 7) ? 32'd1 : 32'd0);
        end
        interpolate_count_ENP = 1'b0;
        init_C = 1'b1; tick();
        init_C = 1'b0;
        check("sat_clear", {31'd0, interpolate_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/foh_interp_datapath.md
Name: foh_interp_datapath

Overview:
- Arithmetic datapath for the first-order-hold (FOH) interpolator. It sits directly downstream of the FOH sequencer FSM and is driven by that FSM's outputs: RegA, RegB, RegC, init_C, interpolate_count_ENP and sample_rdy.
- It holds the two bracketing samples A and B and accumulates the slope. Each interval it emits N = 2^LOG2_N linearly interpolated points: A + floor(k*(B-A)/N), for k = 0..N-1.
- It returns the shift_done and interpolate_count status signals that pace the FSM.

Parameters:
- DATA_W, 12, unsigned sample width.
- LOG2_N, 3, log2 of points per interval; legal range 1..8.

Ports:
- CLOCK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- sample_in  input  DATA_W  unsigned sample from the acquisition stage.
- RegA  input  3  A register control code.
- RegB  input  3  B register control code.
- RegC  input  3  accumulator control code.
- init_C  input  1  recompute slope, clear the point counter, and select the seed value on a RegC load.
- interpolate_count_ENP  input  1  increment the point counter k.
- sample_rdy  input  1  start the output shift for the current point.
- interp_out  output  DATA_W  interpolated sample.
- interp_valid  output  1  one-cycle strobe; interp_out is valid.
- shift_done  output  1  one-cycle pulse; output shift complete.
- interpolate_count  output  1  high while k == N-1 (last point of the interval).

Behaviour:
- Reset: A, B, D, ACC, k, shift register and shift count all clear to 0. interp_out=0, interp_valid=0, shift_done=0, interpolate_count=0.
- Control codes: 3'b001 = LOAD; 3'b000 and all other codes = HOLD.
- RegA==LOAD: A <= sample_in. RegB==LOAD: B <= sample_in. Both may load in the same cycle.
- init_C=1:
  - D <= B - A, signed DATA_W+1, using the registered A and B (pre-edge values).
  - k <= 0.
  - If several consecutive init_C cycles occur, the last one wins.
- RegC==LOAD with init_C=1: ACC <= A << LOG2_N. ACC is signed DATA_W+LOG2_N+1.
- RegC==LOAD with init_C=0: ACC <= ACC + D, sign-extended.
- interpolate_count_ENP=1: k <= k+1, saturating at N-1 (an extra enable holds k).
- interpolate_count is combinational from the registered k: high when k == N-1.
- Shift engine:
  - sample_rdy high in cycle t: shreg <= ACC snapshot, cnt <= LOG2_N.
  - Each following cycle with cnt>0: shreg <= shreg >>> 1, cnt <= cnt-1.
  - On the 1->0 transition of cnt: shift_done and interp_valid both pulse high for exactly one cycle, and interp_out <= shreg[DATA_W-1:0] (final shifted value).
  - Latency: the pulse is registered and visible in cycle t+LOG2_N+1 (for LOG2_N=3, sample_rdy in cycle t gives shift_done in cycle t+4).
- Result bounds: for k in 0..N-1 the result lies in [min(A,B), max(A,B)]; no saturation logic is needed. Arithmetic shift floors toward -inf.
- Boundary conditions:
  - sample_rdy while a shift is in progress: restart from the new ACC snapshot. No pulse is produced for the aborted shift.
  - RegC load during a shift: ACC updates; the shift continues on its snapshot.
  - sample_rdy and RegC load in the same cycle: the snapshot takes the pre-edge ACC.
  - RESET mid-shift: the shift is aborted and no shift_done is produced.
  - interp_out holds its value between strobes.

Decomposition:
- Package foh_pkg holds:
  - REG_HOLD = 3'b000 and REG_LOAD = 3'b001.
  - Default DATA_W and LOG2_N.
  - A width function for the ACC/D widths.
- Sub-module foh_shift_engine: snapshot, iterative arithmetic shift, cnt, and the pulse generation (shift_done, interp_valid, interp_out). The top level keeps the A, B, D, ACC and k registers.

Test Plan:
- Reset check: assert RESET for 3 cycles, releasing mid-stream -> all outputs 0; interpolate_count=0.
- Rising ramp, A=100, B=180, full FSM-style sequence (LOADA, LOADB, init_C, RegC+init_C, then 8 × {sample_rdy, wait for shift_done, RegC+ENP}) -> interp_out = 100,110,120,130,140,150,160,170; interpolate_count high only on the k=7 point.
- Falling ramp, A=200, B=137 (D=-63) -> interp_out = 200,192,184,176,168,160,152,144 (floor rounding).
- Latency: single sample_rdy pulse in cycle t, LOG2_N=3 -> shift_done and interp_valid high only in cycle t+4, each exactly one cycle.
- Retrigger: sample_rdy at t and again at t+2 -> exactly one shift_done, in cycle t+6. RESET asserted at t+1 of another shift -> no pulse at all.
- Saturation: 10 ENP pulses after init_C -> k holds at 7 and interpolate_count stays 1; the next init_C clears it to 0.
